// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types for the 2-write / 2-read register file.
//   rf_state_t : clear-sweep sequencer state (idle or sweeping).
package regfile_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

endpackage

// File: rtl/rf_clear_seq.sv
// rf_clear_seq: clear-sweep sequencer for regfile_2w2r.
// A one-cycle clr_start in idle launches a sweep that visits every register
// once, one per cycle, starting at 0. While sweeping, writes are rejected and
// reported one cycle later on wr_dropped.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   clr_start       sweep request (ignored while sweeping)
//   wr_any          some write port is enabled this cycle
//   busy            registered, high while the sweep runs
//   wr_dropped      registered, high the cycle after a rejected write
//   clr_en          the register at clr_ptr is zeroed at the next edge
//   clr_ptr         sweep pointer
//   idle            writes and bypass are allowed this cycle
module rf_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_start,
  input  logic          wr_any,
  output logic          busy,
  output logic          wr_dropped,
  output logic          clr_en,
  output logic [AW-1:0] clr_ptr,
  output logic          idle
);

  localparam logic [AW-1:0] PTR_ZERO = AW'(32'd0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(32'd1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  rf_state_t     state_r, state_nxt_s;
  logic [AW-1:0] ptr_r, ptr_nxt_s;
  logic          busy_r, drop_r, drop_nxt_s;

  // Next-state, next-pointer and write-drop decode.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    drop_nxt_s  = 1'b0;
    case (state_r)
      RF_IDLE: begin
        if (clr_start) begin
          state_nxt_s = RF_CLEAR;
          ptr_nxt_s   = PTR_ZERO;
        end else begin
          state_nxt_s = RF_IDLE;
        end
      end
      RF_CLEAR: begin
        drop_nxt_s = wr_any;
        // Pointer returns to 0 on the last register so it never passes DEPTH-1.
        if (ptr_r == PTR_LAST) begin
          state_nxt_s = RF_IDLE;
          ptr_nxt_s   = PTR_ZERO;
        end else begin
          ptr_nxt_s   = ptr_r + PTR_ONE;
        end
      end
      default: begin
        state_nxt_s = RF_IDLE;
        ptr_nxt_s   = PTR_ZERO;
      end
    endcase
  end

  // State, pointer and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RF_IDLE;
      ptr_r   <= PTR_ZERO;
      busy_r  <= 1'b0;
      drop_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      busy_r  <= (state_nxt_s == RF_CLEAR);
      drop_r  <= drop_nxt_s;
    end
  end

  assign busy       = busy_r;
  assign wr_dropped = drop_r;
  assign clr_en     = (state_r == RF_CLEAR);
  assign clr_ptr    = ptr_r;
  assign idle       = (state_r == RF_IDLE);

endmodule

// File: rtl/regfile_2w2r.sv
// regfile_2w2r: WIDTH x DEPTH register file, two write ports, two async reads.
// Port B has write priority over port A on the same address. Optional
// same-cycle write-through bypass, optional hardwired-zero register 0, and a
// DEPTH-cycle clear sweep (see rf_clear_seq) during which writes are dropped.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   wrEnA/wrAddrA/wrDataA       write port A
//   wrEnB/wrAddrB/wrDataB       write port B (wins on address collision)
//   rdAddrA/rdDataA             read port A (combinational)
//   rdAddrB/rdDataB             read port B (combinational)
//   clrStart                    start clear sweep
//   busy, wrDropped             registered sweep status
module regfile_2w2r
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int DEPTH    = 16,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrEnA,
  input  logic [AW-1:0]    wrAddrA,
  input  logic [WIDTH-1:0] wrDataA,
  input  logic             wrEnB,
  input  logic [AW-1:0]    wrAddrB,
  input  logic [WIDTH-1:0] wrDataB,
  input  logic [AW-1:0]    rdAddrA,
  output logic [WIDTH-1:0] rdDataA,
  input  logic [AW-1:0]    rdAddrB,
  output logic [WIDTH-1:0] rdDataB,
  input  logic             clrStart,
  output logic             busy,
  output logic             wrDropped
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             idle_s, clr_en_s, wr_any_s, wr_a_s, wr_b_s;
  logic [AW-1:0]    clr_ptr_s;

  // An address is usable when it maps to a real register that is not the
  // hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] addr);
    logic ok;
    ok = ({{(32-AW){1'b0}}, addr} < 32'(DEPTH));
    if ((ZERO_REG != 0) && (addr == AW'(32'd0))) begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  // Read one port: bypass from the winning write port first, then storage.
  function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] raddr);
    logic [WIDTH-1:0] val;
    val = {WIDTH{1'b0}};
    if ((BYPASS != 0) && wr_b_s && (wrAddrB == raddr)) begin
      val = wrDataB;
    end else if ((BYPASS != 0) && wr_a_s && (wrAddrA == raddr)) begin
      val = wrDataA;
    end else if (addr_ok(raddr)) begin
      val = mem_r[raddr];
    end else begin
      val = {WIDTH{1'b0}};
    end
    return val;
  endfunction

  assign wr_any_s = wrEnA | wrEnB;

  rf_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clk        (clk),
    .reset      (reset),
    .clr_start  (clrStart),
    .wr_any     (wr_any_s),
    .busy       (busy),
    .wr_dropped (wrDropped),
    .clr_en     (clr_en_s),
    .clr_ptr    (clr_ptr_s),
    .idle       (idle_s)
  );

  // Qualified write strobes: only legal addresses, only outside a sweep.
  always_comb begin
    wr_a_s = idle_s & wrEnA & addr_ok(wrAddrA);
    wr_b_s = idle_s & wrEnB & addr_ok(wrAddrB);
  end

  // Storage update: reset, then sweep clear, then port B, then port A.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end else if (clr_en_s && (clr_ptr_s == AW'(i))) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end else if (wr_b_s && (wrAddrB == AW'(i))) begin
        mem_r[i] <= wrDataB;
      end else if (wr_a_s && (wrAddrA == AW'(i))) begin
        mem_r[i] <= wrDataA;
      end else begin
        mem_r[i] <= mem_r[i];
      end
    end
  end

  // Asynchronous read muxes.
  always_comb begin
    rdDataA = read_port(rdAddrA);
    rdDataB = read_port(rdAddrB);
  end

endmodule

// File: tb/tb_regfile_2w2r.sv
// tb_regfile_2w2r: three instances share one stimulus stream:
//   dut    WIDTH=16 DEPTH=16 BYPASS=1 ZERO_REG=0
//   dut_nb WIDTH=16 DEPTH=16 BYPASS=0 ZERO_REG=0
//   dut_z  WIDTH=16 DEPTH=12 BYPASS=1 ZERO_REG=1
// Expected values are queued when inputs are driven and popped when sampled.
module tb_regfile_2w2r;

  logic        clk = 1'b0;
  logic        reset, wrEnA, wrEnB, clrStart;
  logic [3:0]  wrAddrA, wrAddrB, rdAddrA, rdAddrB;
  logic [15:0] wrDataA, wrDataB;
  logic [15:0] rd_a, rd_b, nb_rd_a, nb_rd_b, z_rd_a, z_rd_b;
  logic        busy, drop, nb_busy, nb_drop, z_busy, z_drop;

  always #5 clk = ~clk;

  regfile_2w2r #(.WIDTH(16), .DEPTH(16), .BYPASS(1), .ZERO_REG(0)) dut (
    .clk(clk), .reset(reset),
    .wrEnA(wrEnA), .wrAddrA(wrAddrA), .wrDataA(wrDataA),
    .wrEnB(wrEnB), .wrAddrB(wrAddrB), .wrDataB(wrDataB),
    .rdAddrA(rdAddrA), .rdDataA(rd_a), .rdAddrB(rdAddrB), .rdDataB(rd_b),
    .clrStart(clrStart), .busy(busy), .wrDropped(drop));

  regfile_2w2r #(.WIDTH(16), .DEPTH(16), .BYPASS(0), .ZERO_REG(0)) dut_nb (
    .clk(clk), .reset(reset),
    .wrEnA(wrEnA), .wrAddrA(wrAddrA), .wrDataA(wrDataA),
    .wrEnB(wrEnB), .wrAddrB(wrAddrB), .wrDataB(wrDataB),
    .rdAddrA(rdAddrA), .rdDataA(nb_rd_a), .rdAddrB(rdAddrB), .rdDataB(nb_rd_b),
    .clrStart(clrStart), .busy(nb_busy), .wrDropped(nb_drop));

  regfile_2w2r #(.WIDTH(16), .DEPTH(12), .BYPASS(1), .ZERO_REG(1)) dut_z (
    .clk(clk), .reset(reset),
    .wrEnA(wrEnA), .wrAddrA(wrAddrA), .wrDataA(wrDataA),
    .wrEnB(wrEnB), .wrAddrB(wrAddrB), .wrDataB(wrDataB),
    .rdAddrA(rdAddrA), .rdDataA(z_rd_a), .rdAddrB(rdAddrB), .rdDataB(z_rd_b),
    .clrStart(clrStart), .busy(z_busy), .wrDropped(z_drop));

  localparam int T_RDA = 0, T_RDB = 1, T_NRDA = 2, T_NRDB = 3, T_ZRDA = 4,
                 T_ZRDB = 5, T_BUSY = 6, T_DROP = 7, T_ZBUSY = 8, T_ZDROP = 9,
                 T_NBUSY = 10;

  typedef struct {
    int          tag;
    logic [15:0] val;
  } exp_t;

  typedef struct {
    logic        weA; logic [3:0] waA; logic [15:0] wdA;
    logic        weB; logic [3:0] waB; logic [15:0] wdB;
    logic [3:0]  raA; logic [3:0] raB;
    logic [15:0] ea, eb, na, nb, za, zb;
  } vec_t;

  exp_t exp_q[$];
  vec_t vt[12];
  int   n_cmp = 0;
  int   n_err = 0;
  int   bcnt, zcnt;

  function automatic string tag_name(int tag);
    case (tag)
      T_RDA:   return "rdDataA";
      T_RDB:   return "rdDataB";
      T_NRDA:  return "nobypass.rdDataA";
      T_NRDB:  return "nobypass.rdDataB";
      T_ZRDA:  return "zero.rdDataA";
      T_ZRDB:  return "zero.rdDataB";
      T_BUSY:  return "busy";
      T_DROP:  return "wrDropped";
      T_ZBUSY: return "zero.busy";
      T_ZDROP: return "zero.wrDropped";
      T_NBUSY: return "nobypass.busy";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [15:0] get_out(int tag);
    case (tag)
      T_RDA:   return rd_a;
      T_RDB:   return rd_b;
      T_NRDA:  return nb_rd_a;
      T_NRDB:  return nb_rd_b;
      T_ZRDA:  return z_rd_a;
      T_ZRDB:  return z_rd_b;
      T_BUSY:  return {15'd0, busy};
      T_DROP:  return {15'd0, drop};
      T_ZBUSY: return {15'd0, z_busy};
      T_ZDROP: return {15'd0, z_drop};
      T_NBUSY: return {15'd0, nb_busy};
      default: return 16'hxxxx;
    endcase
  endfunction

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input int tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp(tag_name(e.tag), get_out(e.tag), e.val);
    end
  endtask

  task automatic idle_inputs();
    wrEnA = 1'b0; wrAddrA = 4'd0; wrDataA = 16'h0000;
    wrEnB = 1'b0; wrAddrB = 4'd0; wrDataB = 16'h0000;
    clrStart = 1'b0;
  endtask

  // r0..r15 = i+1, two registers per cycle; dut_z ignores r0 and r12..r15.
  task automatic fill_all();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wrEnA = 1'b1; wrAddrA = 4'(i);     wrDataA = 16'(i + 1);
      wrEnB = 1'b1; wrAddrB = 4'(i + 8); wrDataB = 16'(i + 9);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  // Read every address on both ports; storage is expected to be all zero.
  task automatic read_all_zero();
    for (int i = 0; i < 16; i++) begin
      rdAddrA = 4'(i); rdAddrB = 4'(15 - i);
      #1;
      push(T_RDA, 16'h0000); push(T_RDB, 16'h0000);
      push(T_NRDA, 16'h0000); push(T_ZRDA, 16'h0000);
      check_all();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            weA  waA    wdA       weB  waB    wdB       raA    raB    ea        eb        na        nb        za        zb
    vt[0]  = '{1'b1, 4'd3,  16'h00AA, 1'b1, 4'd5,  16'h0055, 4'd3,  4'd5,  16'h00AA, 16'h0055, 16'h0000, 16'h0000, 16'h00AA, 16'h0055};
    vt[1]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  16'h0000, 4'd3,  4'd5,  16'h00AA, 16'h0055, 16'h00AA, 16'h0055, 16'h00AA, 16'h0055};
    vt[2]  = '{1'b1, 4'd7,  16'h1111, 1'b1, 4'd7,  16'h2222, 4'd7,  4'd7,  16'h2222, 16'h2222, 16'h0000, 16'h0000, 16'h2222, 16'h2222};
    vt[3]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  16'h0000, 4'd7,  4'd3,  16'h2222, 16'h00AA, 16'h2222, 16'h00AA, 16'h2222, 16'h00AA};
    vt[4]  = '{1'b1, 4'd4,  16'hBEEF, 1'b0, 4'd0,  16'h0000, 4'd4,  4'd5,  16'hBEEF, 16'h0055, 16'h0000, 16'h0055, 16'hBEEF, 16'h0055};
    vt[5]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  16'h0000, 4'd4,  4'd4,  16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
    vt[6]  = '{1'b1, 4'd0,  16'hFFFF, 1'b0, 4'd0,  16'h0000, 4'd0,  4'd0,  16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vt[7]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  16'h0000, 4'd0,  4'd0,  16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
    vt[8]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd13, 16'h1234, 4'd13, 4'd13, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vt[9]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  16'h0000, 4'd13, 4'd0,  16'h1234, 16'hFFFF, 16'h1234, 16'hFFFF, 16'h0000, 16'h0000};
    vt[10] = '{1'b1, 4'd12, 16'h5555, 1'b1, 4'd11, 16'h6666, 4'd12, 4'd11, 16'h5555, 16'h6666, 16'h0000, 16'h0000, 16'h0000, 16'h6666};
    vt[11] = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  16'h0000, 4'd12, 4'd11, 16'h5555, 16'h6666, 16'h5555, 16'h6666, 16'h0000, 16'h6666};

    // Reset state.
    idle_inputs();
    reset = 1'b1; rdAddrA = 4'd3; rdAddrB = 4'd5;
    @(posedge clk); #1;
    push(T_BUSY, 16'd0); push(T_DROP, 16'd0); push(T_ZBUSY, 16'd0); push(T_ZDROP, 16'd0);
    push(T_RDA, 16'h0000); push(T_RDB, 16'h0000); push(T_NRDA, 16'h0000); push(T_ZRDB, 16'h0000);
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // Table: port writes, priority, bypass, zero register, out-of-range.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      wrEnA = vt[k].weA; wrAddrA = vt[k].waA; wrDataA = vt[k].wdA;
      wrEnB = vt[k].weB; wrAddrB = vt[k].waB; wrDataB = vt[k].wdB;
      rdAddrA = vt[k].raA; rdAddrB = vt[k].raB;
      push(T_RDA, vt[k].ea);  push(T_RDB, vt[k].eb);
      push(T_NRDA, vt[k].na); push(T_NRDB, vt[k].nb);
      push(T_ZRDA, vt[k].za); push(T_ZRDB, vt[k].zb);
      #2 check_all();
      @(posedge clk); #1;
      push(T_BUSY, 16'd0); push(T_DROP, 16'd0);
      check_all();
    end

    // Fill and read back.
    fill_all();
    for (int i = 0; i < 16; i++) begin
      rdAddrA = 4'(i); rdAddrB = 4'(15 - i);
      #1;
      push(T_RDA, 16'(i + 1)); push(T_RDB, 16'(16 - i));
      push(T_ZRDA, (i == 0 || i >= 12) ? 16'h0000 : 16'(i + 1));
      check_all();
    end

    // Clear sweep with a write attempted on sweep cycle 3.
    @(negedge clk);
    clrStart = 1'b1;
    @(posedge clk); #1;
    bcnt = int'(busy); zcnt = int'(z_busy);
    @(negedge clk);
    clrStart = 1'b0;
    for (int c = 0; c < 40; c++) begin
      wrEnA = (c == 3); wrAddrA = 4'd2; wrDataA = 16'h0009;
      rdAddrA = 4'd2; rdAddrB = 4'd15;
      if (c == 3) begin
        push(T_RDA, 16'h0000); push(T_ZRDA, 16'h0000);
      end
      #2 check_all();
      @(posedge clk); #1;
      bcnt += int'(busy); zcnt += int'(z_busy);
      push(T_DROP, (c == 3) ? 16'd1 : 16'd0);
      push(T_ZDROP, (c == 3) ? 16'd1 : 16'd0);
      check_all();
      if (!busy && !z_busy) break;
      @(negedge clk);
    end
    idle_inputs();
    cmp("busy_cycles", 16'(bcnt), 16'd16);
    cmp("zero.busy_cycles", 16'(zcnt), 16'd12);
    @(negedge clk);
    read_all_zero();

    // Reset in the middle of a sweep.
    fill_all();
    @(negedge clk);
    clrStart = 1'b1;
    @(negedge clk);
    clrStart = 1'b0;
    for (int c = 0; c < 5; c++) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    push(T_BUSY, 16'd0); push(T_DROP, 16'd0); push(T_ZBUSY, 16'd0); push(T_NBUSY, 16'd0);
    check_all();
    @(negedge clk);
    reset = 1'b0;
    read_all_zero();

    // Write after the aborted sweep must land.
    @(negedge clk);
    wrEnA = 1'b1; wrAddrA = 4'd1; wrDataA = 16'h0077; rdAddrA = 4'd1;
    push(T_RDA, 16'h0077); push(T_NRDA, 16'h0000);
    #2 check_all();
    @(negedge clk);
    idle_inputs();
    #1;
    push(T_RDA, 16'h0077); push(T_NRDA, 16'h0077); push(T_ZRDA, 16'h0077);
    push(T_BUSY, 16'd0);
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
